// File: rtl/bcd_pkg.sv
// Shared BCD digit type and digit limits for the BCD up/down counter.
package bcd_pkg;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;
  typedef logic [3:0] bcd_digit_t;
endpackage

// File: rtl/bcd_digit.sv
// One BCD digit (0..9) with synchronous load; advances on the edge where step and cin are both high.
// cout is combinational from q and up, so carry/borrow ripples through a chain within one cycle.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       Clk,
  input  logic       RST,
  input  logic       load,
  input  bcd_digit_t load_val,
  input  logic       step,
  input  logic       up,
  input  logic       cin,
  output bcd_digit_t q,
  output logic       cout
);

  always_ff @(posedge Clk) begin
    if (RST) begin
      q <= BCD_MIN;
    end else if (load) begin
      // Non-BCD load values are squashed so q never leaves 0..9.
      q <= (load_val > BCD_MAX) ? BCD_MIN : load_val;
    end else if (step && cin) begin
      if (up) q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
      else    q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
    end
  end

  assign cout = up ? (q == BCD_MAX) : (q == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with tick prescaler, load, and wrap/saturate limits.
// COUNT/STEP/TC update on the stepping edge (1 edge); EN=0 freezes prescaler and count.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int PRESCALE   = 1,
  parameter bit WRAP       = 1'b1
) (
  input  logic                    Clk,
  input  logic                    RST,
  input  logic                    EN,
  input  logic                    UP,
  input  logic                    LOAD,
  input  logic [4*NUM_DIGITS-1:0] LOAD_VAL,
  output logic [4*NUM_DIGITS-1:0] COUNT,
  output logic                    STEP,
  output logic                    TC
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]         pre;
  logic                  tick;
  logic                  at_limit;
  logic                  do_step;
  logic [NUM_DIGITS-1:0] cin;
  logic [NUM_DIGITS-1:0] cout;

  always_ff @(posedge Clk) begin
    if (RST || LOAD) pre <= '0;
    else if (EN)     pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
  end

  assign tick     = EN && !LOAD && (pre == PRE_LAST);
  assign at_limit = &cout;
  // In saturate mode a step at the limit is suppressed but still flagged on TC.
  assign do_step  = tick && (WRAP || !at_limit);

  genvar k;
  generate
    for (k = 0; k < NUM_DIGITS; k++) begin : g_digit
      if (k == 0) begin : g_first
        assign cin[k] = do_step;
      end else begin : g_next
        assign cin[k] = cin[k-1] & cout[k-1];
      end
      bcd_digit u_digit (
        .Clk      (Clk),
        .RST      (RST),
        .load     (LOAD),
        .load_val (LOAD_VAL[4*k +: 4]),
        .step     (do_step),
        .up       (UP),
        .cin      (cin[k]),
        .q        (COUNT[4*k +: 4]),
        .cout     (cout[k])
      );
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (RST) begin
      STEP <= 1'b0;
      TC   <= 1'b0;
    end else begin
      STEP <= do_step;
      TC   <= tick && at_limit;
    end
  end

endmodule
